vend_ctrl: RTL and testbench
============================

Name: vend_ctrl

Overview:
Transaction controller for the vending datapath. It accumulates coin credit from the coin acceptor and accepts a product selection. It drives a req/ack handshake to the dispense mechanism, then pays out change as one or more valid/ready beats of up to COIN_MAX each. It sits between the coin/keypad front end and the dispense motor and refund hopper.

Parameters:
PRICE0, 5, price of item 0
PRICE1, 7, price of item 1
PRICE2, 10, price of item 2
PRICE3, 12, price of item 3
MAX_CREDIT, 40, highest credit held; a coin that would exceed it is rejected
COIN_MAX, 15, largest value paid in one change beat
ACK_TIMEOUT, 16, cycles to wait for disp_ack before declaring a fault

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
coin_in  in  1  one coin per cycle in which it is high
coin_value  in  4  value of the coin, valid with coin_in
sel_valid  in  1  one-cycle selection strobe
sel_item  in  2  selected item, valid with sel_valid
cancel  in  1  one-cycle request to refund all credit
disp_req  out  1  dispense request, held until ack or timeout
disp_item  out  2  item to dispense, stable while disp_req is high
disp_ack  in  1  one-cycle completion from the dispense mechanism
change_valid  out  1  change beat valid
change_value  out  4  value of the change beat
change_ready  in  1  hopper accepts the beat
credit  out  6  current credit, registered
busy  out  1  high in DISPENSE or CHANGE
coin_reject  out  1  one-cycle pulse when a coin is rejected
sel_short  out  1  one-cycle pulse on a selection with insufficient credit
disp_fault  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset (reset low, asynchronous): state IDLE; credit=0; all outputs 0; timeout counter 0.
- States: IDLE (credit==0), CREDIT (credit>0), DISPENSE, CHANGE.
- Coins in IDLE or CREDIT:
  - coin_in=1 with coin_value!=0 and credit+coin_value<=MAX_CREDIT: credit updates on the next edge; IDLE moves to CREDIT.
  - Overflow, or any coin while busy: coin_reject pulses the next cycle; credit is unchanged.
  - coin_value==0 is ignored silently.
- Selection in CREDIT:
  - sel_valid with credit>=PRICE[sel_item]: credit-=price, disp_item latched, disp_req=1 the next cycle, state DISPENSE.
  - Otherwise sel_short pulses and the state is unchanged.
  - sel_valid in IDLE: sel_short pulses.
- Simultaneous events in CREDIT:
  - cancel has priority over sel_valid; cancel moves to CHANGE with the full credit.
  - cancel in IDLE is ignored.
  - A coin in the same cycle as an accepted selection is still added. The price comparison uses the credit before that coin.
- DISPENSE:
  - disp_req and disp_item are held; the timeout counter increments each cycle.
  - disp_ack=1: disp_req drops the next cycle; go to CHANGE if credit>0, else IDLE.
  - Counter reaches ACK_TIMEOUT with no ack: disp_fault pulses, the price is added back to credit, disp_req drops, state CHANGE.
  - disp_ack outside DISPENSE is ignored.
- CHANGE:
  - change_valid=1, change_value=min(credit, COIN_MAX).
  - On valid&&ready, credit-=change_value. change_value updates the next cycle; it is held stable while ready is low.
  - When credit reaches 0, change_valid drops that same next cycle and the state returns to IDLE.
  - cancel and sel_valid are ignored in CHANGE.
- busy=1 in DISPENSE and CHANGE.
- Arithmetic: credit is 6-bit unsigned; sums are computed at 7 bits for the overflow check. Prices must satisfy 0<PRICEn<=MAX_CREDIT, and MAX_CREDIT<64.
- Reset mid-transaction discards credit and drops disp_req and change_valid immediately.

Decomposition:
- vend_pkg holds:
  - the state enum: IDLE, CREDIT, DISPENSE, CHANGE;
  - CREDIT_W=6 and COIN_W=4;
  - the default price constants;
  - a function price_of(item).
- One sub-module, vend_change_unit, is natural: the min(credit, COIN_MAX) beat generator with its valid/ready hold logic.
- The top level keeps the FSM, credit register and timeout counter.

Test Plan:
1. Coins 5,7 -> credit=12; sel_item=3 -> disp_req=1, disp_item=3, credit=0; ack -> IDLE, no change_valid.
2. Coins 7,7,3 (credit=17); sel_item=2 -> dispense; ack -> one change beat of 7; credit=0, IDLE.
3. Coins 15,15,10 (credit=40), then cancel -> beats 15,15,10. Holding change_ready low keeps change_value=15 stable.
4. Credit=3, sel_item=0 -> sel_short pulse, credit stays 3. Coin 2 -> credit=5; sel_item=0 -> dispense, credit=0.
5. Credit=12, sel_item=3, no disp_ack -> after 16 cycles disp_fault pulses and credit=12. Then a change beat of 12; a coin inserted during DISPENSE -> coin_reject.
6. Credit=35, coin 7 -> coin_reject, credit stays 35. Then cancel and assert reset low during CHANGE -> credit=0 and all outputs 0 asynchronously.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types, widths and price lookup for the vending transaction controller.
package vend_pkg;

  localparam int unsigned CREDIT_W = 6;
  localparam int unsigned COIN_W   = 4;

  localparam int unsigned PRICE0_DEF = 5;
  localparam int unsigned PRICE1_DEF = 7;
  localparam int unsigned PRICE2_DEF = 10;
  localparam int unsigned PRICE3_DEF = 12;

  typedef enum logic [1:0] {
    StIdle,
    StCredit,
    StDispense,
    StChange
  } vend_state_e;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] item,
                                                   input int unsigned p0,
                                                   input int unsigned p1,
                                                   input int unsigned p2,
                                                   input int unsigned p3);
    logic [CREDIT_W-1:0] price;
    price = '0;
    case (item)
      2'd0: price = CREDIT_W'(p0);
      2'd1: price = CREDIT_W'(p1);
      2'd2: price = CREDIT_W'(p2);
      default: price = CREDIT_W'(p3);
    endcase
    return price;
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Change beat generator: offers min(credit, COIN_MAX) while active. The beat value is derived
// from the registered credit, so it cannot move until the hopper takes it.
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int unsigned COIN_MAX = 15
) (
  input  logic                active,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                change_ready,
  output logic                change_valid,
  output logic [COIN_W-1:0]   change_value,
  output logic                fire
);

  localparam logic [CREDIT_W-1:0] CoinMaxC = CREDIT_W'(COIN_MAX);

  always_comb begin
    change_valid = active;
    change_value = '0;
    fire         = active && change_ready;
    if (active) begin
      change_value = (credit > CoinMaxC) ? COIN_W'(COIN_MAX) : credit[COIN_W-1:0];
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: credit accumulation, selection, dispense handshake with
// ack timeout, and change payout.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0      = PRICE0_DEF,
  parameter int unsigned PRICE1      = PRICE1_DEF,
  parameter int unsigned PRICE2      = PRICE2_DEF,
  parameter int unsigned PRICE3      = PRICE3_DEF,
  parameter int unsigned MAX_CREDIT  = 40,
  parameter int unsigned COIN_MAX    = 15,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_in,
  input  logic [COIN_W-1:0]   coin_value,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  input  logic                cancel,
  output logic                disp_req,
  output logic [1:0]          disp_item,
  input  logic                disp_ack,
  output logic                change_valid,
  output logic [COIN_W-1:0]   change_value,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                sel_short,
  output logic                disp_fault
);

  localparam int unsigned SumW = CREDIT_W + 1;
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          item_q, item_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_short_q, sel_short_d;
  logic                fault_q, fault_d;

  logic [SumW-1:0]     coin_sum;
  logic                coin_ok, coin_bad;
  logic [CREDIT_W-1:0] coin_add, sel_price, disp_price, credit_after;
  logic                chg_fire;

  // Overflow check is done one bit wider so a wrapping sum is still caught.
  assign coin_sum = {1'b0, credit_q} + SumW'(coin_value);
  assign coin_ok  = coin_in && (coin_value != '0) && (coin_sum <= SumW'(MAX_CREDIT)) &&
                    ((state_q == StIdle) || (state_q == StCredit));
  assign coin_bad = coin_in && (coin_value != '0) && !coin_ok;
  assign coin_add = coin_ok ? CREDIT_W'(coin_value) : '0;

  assign sel_price  = price_of(sel_item, PRICE0, PRICE1, PRICE2, PRICE3);
  assign disp_price = price_of(item_q, PRICE0, PRICE1, PRICE2, PRICE3);

  vend_change_unit #(
    .COIN_MAX(COIN_MAX)
  ) u_change (
    .active      (state_q == StChange),
    .credit      (credit_q),
    .change_ready(change_ready),
    .change_valid(change_valid),
    .change_value(change_value),
    .fire        (chg_fire)
  );

  assign credit_after = credit_q - CREDIT_W'(change_value);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    item_d        = item_q;
    cnt_d         = cnt_q;
    coin_reject_d = coin_bad;
    sel_short_d   = 1'b0;
    fault_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        credit_d = credit_q + coin_add;
        if (coin_ok) state_d = StCredit;
        if (sel_valid) sel_short_d = 1'b1;
      end
      StCredit: begin
        credit_d = credit_q + coin_add;
        if (cancel) begin
          state_d = StChange;
        end else if (sel_valid) begin
          // Price is judged against the credit held before any same-cycle coin.
          if (credit_q >= sel_price) begin
            credit_d = credit_q - sel_price + coin_add;
            item_d   = sel_item;
            cnt_d    = '0;
            state_d  = StDispense;
          end else begin
            sel_short_d = 1'b1;
          end
        end
      end
      StDispense: begin
        if (disp_ack) begin
          cnt_d   = '0;
          state_d = (credit_q != '0) ? StChange : StIdle;
        end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
          cnt_d    = '0;
          fault_d  = 1'b1;
          credit_d = credit_q + disp_price;
          state_d  = StChange;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StChange: begin
        if (chg_fire) begin
          credit_d = credit_after;
          if (credit_after == '0) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      item_q        <= '0;
      cnt_q         <= '0;
      coin_reject_q <= 1'b0;
      sel_short_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      item_q        <= item_d;
      cnt_q         <= cnt_d;
      coin_reject_q <= coin_reject_d;
      sel_short_q   <= sel_short_d;
      fault_q       <= fault_d;
    end
  end

  assign disp_req    = (state_q == StDispense);
  assign disp_item   = item_q;
  assign credit      = credit_q;
  assign busy        = (state_q == StDispense) || (state_q == StChange);
  assign coin_reject = coin_reject_q;
  assign sel_short   = sel_short_q;
  assign disp_fault  = fault_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl with hand-computed expectations.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_in;
  logic [3:0] coin_value;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       disp_ack;
  logic       change_valid;
  logic [3:0] change_value;
  logic       change_ready;
  logic [5:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       sel_short;
  logic       disp_fault;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  vend_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .coin_in     (coin_in),
    .coin_value  (coin_value),
    .sel_valid   (sel_valid),
    .sel_item    (sel_item),
    .cancel      (cancel),
    .disp_req    (disp_req),
    .disp_item   (disp_item),
    .disp_ack    (disp_ack),
    .change_valid(change_valid),
    .change_value(change_value),
    .change_ready(change_ready),
    .credit      (credit),
    .busy        (busy),
    .coin_reject (coin_reject),
    .sel_short   (sel_short),
    .disp_fault  (disp_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    coin_in   = 1'b0;
    sel_valid = 1'b0;
    cancel    = 1'b0;
    disp_ack  = 1'b0;
  endtask

  task automatic coin(input logic [3:0] v);
    coin_in    = 1'b1;
    coin_value = v;
    step();
  endtask

  task automatic select(input logic [1:0] item);
    sel_valid = 1'b1;
    sel_item  = item;
    step();
  endtask

  task automatic ack();
    disp_ack = 1'b1;
    step();
  endtask

  initial begin
    reset        = 1'b0;
    coin_in      = 1'b0;
    coin_value   = '0;
    sel_valid    = 1'b0;
    sel_item     = '0;
    cancel       = 1'b0;
    disp_ack     = 1'b0;
    change_ready = 1'b0;
    #12;
    check("rst_credit", credit, 0);
    check("rst_disp_req", disp_req, 0);
    check("rst_change_valid", change_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {coin_reject, sel_short, disp_fault}, 0);
    reset = 1'b1;
    #10;

    // 1: exact payment, no change.
    coin(4'd5);
    coin(4'd7);
    check("t1_credit", credit, 12);
    select(2'd3);
    check("t1_disp_req", disp_req, 1);
    check("t1_disp_item", disp_item, 3);
    check("t1_credit_after_sel", credit, 0);
    check("t1_busy", busy, 1);
    ack();
    check("t1_req_drop", disp_req, 0);
    check("t1_no_change", change_valid, 0);
    check("t1_idle", busy, 0);

    // 2: one change beat after dispense.
    coin(4'd7);
    coin(4'd7);
    coin(4'd3);
    check("t2_credit", credit, 17);
    select(2'd2);
    check("t2_disp_req", disp_req, 1);
    check("t2_credit_sel", credit, 7);
    ack();
    check("t2_change_valid", change_valid, 1);
    check("t2_change_value", change_value, 7);
    change_ready = 1'b1;
    step();
    change_ready = 1'b0;
    check("t2_credit_end", credit, 0);
    check("t2_valid_end", change_valid, 0);
    check("t2_idle", busy, 0);

    // 3: full refund at max credit, beats 15,15,10 with backpressure.
    coin(4'd15);
    coin(4'd15);
    coin(4'd10);
    check("t3_credit", credit, 40);
    cancel = 1'b1;
    step();
    check("t3_valid", change_valid, 1);
    check("t3_beat0", change_value, 15);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_value", change_value, 15);
      check("t3_hold_credit", credit, 40);
    end
    change_ready = 1'b1;
    step();
    check("t3_credit1", credit, 25);
    check("t3_beat1", change_value, 15);
    step();
    check("t3_credit2", credit, 10);
    check("t3_beat2", change_value, 10);
    step();
    change_ready = 1'b0;
    check("t3_credit_end", credit, 0);
    check("t3_valid_end", change_valid, 0);
    check("t3_idle", busy, 0);

    // 4: short selection, then top up and buy.
    coin(4'd3);
    select(2'd0);
    check("t4_sel_short", sel_short, 1);
    check("t4_credit_kept", credit, 3);
    check("t4_no_req", disp_req, 0);
    step();
    check("t4_short_pulse", sel_short, 0);
    coin(4'd2);
    check("t4_credit5", credit, 5);
    select(2'd0);
    check("t4_disp_req", disp_req, 1);
    check("t4_credit0", credit, 0);
    ack();
    check("t4_idle", busy, 0);

    // 5: ack timeout refunds the price; coin during dispense rejected.
    coin(4'd5);
    coin(4'd7);
    select(2'd3);
    check("t5_disp_req", disp_req, 1);
    coin(4'd1);
    check("t5_coin_reject", coin_reject, 1);
    check("t5_credit_busy", credit, 0);
    for (int i = 0; i < 14; i++) step();
    check("t5_req_held", disp_req, 1);
    check("t5_no_fault_yet", disp_fault, 0);
    step();
    check("t5_fault", disp_fault, 1);
    check("t5_req_drop", disp_req, 0);
    check("t5_credit_back", credit, 12);
    check("t5_change_valid", change_valid, 1);
    check("t5_change_value", change_value, 12);
    change_ready = 1'b1;
    step();
    change_ready = 1'b0;
    check("t5_fault_pulse", disp_fault, 0);
    check("t5_credit_end", credit, 0);
    check("t5_idle", busy, 0);

    // 6: overflow rejection, then async reset during change.
    coin(4'd15);
    coin(4'd15);
    coin(4'd5);
    check("t6_credit35", credit, 35);
    coin(4'd7);
    check("t6_coin_reject", coin_reject, 1);
    check("t6_credit_kept", credit, 35);
    cancel = 1'b1;
    step();
    check("t6_change_valid", change_valid, 1);
    check("t6_change_value", change_value, 15);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_credit", credit, 0);
    check("t6_rst_valid", change_valid, 0);
    check("t6_rst_value", change_value, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_req", disp_req, 0);
    #3;
    reset = 1'b1;
    step();
    check("t6_after_rst", {busy, change_valid, credit}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
